multicycle_datapath: RTL and testbench

Parametrised second-generation multicycle MIPS datapath. Holds the architectural and inter-cycle state: PC, IR, MDR, A, B, ALUOut and the register file. It is steered cycle by cycle by the external controller; the ALU itself is external. Compared with the first generation it adds:
- configurable address width and reset vector
- memory-ready handshake and a global stall
- bne, jal and jr support
- zero-extension option for immediates

---
 rtl/multicycle_datapath_if.sv | 43 ++++
 rtl/multicycle_datapath.sv | 118 +++++++++++
 tb/tb_multicycle_datapath.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_datapath_if.sv
// Control/data bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_datapath_if #(
  parameter int ADDR_W = 16
);
  logic              stall;
  logic              memReady;
  logic              PCWrite;
  logic              PCWriteCond;
  logic              PCWriteCondNe;
  logic [1:0]        PCSource;
  logic              IorD;
  logic              IRWrite;
  logic              RegWrite;
  logic [1:0]        RegDst;
  logic [1:0]        MemToReg;
  logic              ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic              ExtOp;
  logic              zero;
  logic [31:0]       aluResult;
  logic [31:0]       memData;
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [31:0]       aluParamData1;
  logic [31:0]       aluParamData2;
  logic [31:0]       writeMemData;
  logic [ADDR_W-1:0] memAddr;
  logic [ADDR_W-1:0] pcOut;

  modport master (
    output stall, memReady, PCWrite, PCWriteCond, PCWriteCondNe, PCSource, IorD,
           IRWrite, RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ExtOp, zero,
           aluResult, memData,
    input  op, funct, aluParamData1, aluParamData2, writeMemData, memAddr, pcOut
  );

  modport slave (
    input  stall, memReady, PCWrite, PCWriteCond, PCWriteCondNe, PCSource, IorD,
           IRWrite, RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ExtOp, zero,
           aluResult, memData,
    output op, funct, aluParamData1, aluParamData2, writeMemData, memAddr, pcOut
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut and a 32x32 register file.
// All sequencing comes from the external controller; the ALU is external too.
module multicycle_datapath #(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_datapath_if.slave bus
);

  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir, mdr, regA, regB, aluOut;
  logic [31:0]       regs [32];

  logic [4:0]        rs, rt, rd, wAddr;
  logic [31:0]       pcExt, immExt, jumpTarget, pcSrc, wData, rdA, rdB;
  logic              pcEn, regWe;

  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign pcExt = 32'(pc);

  assign immExt     = bus.ExtOp ? {{16{ir[15]}}, ir[15:0]} : {16'h0, ir[15:0]};
  // Upper PC bits only matter above bit 27; for narrow PCs they are zero anyway.
  assign jumpTarget = {pcExt[31:28], ir[25:0], 2'b00};

  // Combinational register reads; r0 optionally hardwired to zero.
  assign rdA = (ZERO_REG && rs == 5'd0) ? 32'h0 : regs[rs];
  assign rdB = (ZERO_REG && rt == 5'd0) ? 32'h0 : regs[rt];

  // Next-PC source, write-back mux and write enables.
  always_comb begin
    pcSrc = bus.aluResult;
    case (bus.PCSource)
      2'b00: pcSrc = bus.aluResult;
      2'b01: pcSrc = aluOut;
      2'b10: pcSrc = jumpTarget;
      2'b11: pcSrc = regA;
    endcase
    wAddr = rt;
    case (bus.RegDst)
      2'b01:   wAddr = rd;
      2'b10:   wAddr = 5'd31;
      default: wAddr = rt;
    endcase
    wData = aluOut;
    case (bus.MemToReg)
      2'b01:   wData = mdr;
      2'b10:   wData = pcExt;
      default: wData = aluOut;
    endcase
    pcEn  = !bus.stall && (bus.PCWrite || (bus.PCWriteCond && bus.zero) ||
                           (bus.PCWriteCondNe && !bus.zero));
    regWe = bus.RegWrite && !bus.stall && !(ZERO_REG && wAddr == 5'd0);
  end

  // Program counter; wraps naturally at ADDR_W bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pc <= RESET_PC[ADDR_W-1:0];
    else if (pcEn) pc <= pcSrc[ADDR_W-1:0];
  end

  // Instruction register: only captures once memory reports data valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          ir <= '0;
    else if (bus.IRWrite && bus.memReady && !bus.stall) ir <= bus.memData;
  end

  // Memory data register: captures every valid memory beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           mdr <= '0;
    else if (bus.memReady && !bus.stall) mdr <= bus.memData;
  end

  // Inter-cycle operand/result latches, reloaded every unstalled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regA   <= '0;
      regB   <= '0;
      aluOut <= '0;
    end else if (!bus.stall) begin
      regA   <= rdA;
      regB   <= rdB;
      aluOut <= bus.aluResult;
    end
  end

  // Register file write port; reads see the old value in the write cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (regWe) begin
      regs[wAddr] <= wData;
    end
  end

  assign bus.op            = ir[31:26];
  assign bus.funct         = ir[5:0];
  assign bus.aluParamData1 = bus.ALUSrcA ? regA : pcExt;
  assign bus.writeMemData  = regB;
  assign bus.memAddr       = bus.IorD ? aluOut[ADDR_W-1:0] : pc;
  assign bus.pcOut         = pc;

  // Second ALU operand select.
  always_comb begin
    bus.aluParamData2 = regB;
    case (bus.ALUSrcB)
      2'b00: bus.aluParamData2 = regB;
      2'b01: bus.aluParamData2 = 32'd4;
      2'b10: bus.aluParamData2 = immExt;
      2'b11: bus.aluParamData2 = {immExt[29:0], 2'b00};
    endcase
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath; expectations go to a scoreboard queue
// and a monitor compares them against the DUT outputs on each falling edge.
module tb_multicycle_datapath;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multicycle_datapath_if #(.ADDR_W(16)) bus();

  multicycle_datapath #(.ADDR_W(16), .RESET_PC(32'h0040), .ZERO_REG(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef enum int {S_PC, S_MADDR, S_OP, S_FUNCT, S_A1, S_A2, S_WMD} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   nCmp = 0;
  int   nBad = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_PC:    return 32'(bus.pcOut);
      S_MADDR: return 32'(bus.memAddr);
      S_OP:    return 32'(bus.op);
      S_FUNCT: return 32'(bus.funct);
      S_A1:    return bus.aluParamData1;
      S_A2:    return bus.aluParamData2;
      default: return bus.writeMemData;
    endcase
  endfunction

  task automatic push(input string n, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = s; e.exp = v;
    sbq.push_back(e);
  endtask

  // Monitor: drains every pending expectation at each falling edge.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = observe(e.sel);
        nCmp++;
        if (act !== e.exp) begin
          nBad++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // One rising edge; inputs may change 1 time unit afterwards.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.memReady = 0; bus.PCWrite = 0; bus.PCWriteCond = 0;
    bus.PCWriteCondNe = 0; bus.PCSource = 0; bus.IorD = 0; bus.IRWrite = 0;
    bus.RegWrite = 0; bus.RegDst = 0; bus.MemToReg = 0; bus.ALUSrcA = 0;
    bus.ALUSrcB = 0; bus.ExtOp = 0; bus.zero = 0;
  endtask

  task automatic loadIR(input logic [31:0] v);
    bus.memData = v; bus.IRWrite = 1; bus.memReady = 1;
    tick();
    bus.IRWrite = 0; bus.memReady = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    bus.aluResult = 0;
    bus.memData   = 0;

    // Reset state
    push("rst_pc", S_PC, 32'h40);
    push("rst_maddr", S_MADDR, 32'h40);
    push("rst_op", S_OP, 32'h0);
    push("rst_funct", S_FUNCT, 32'h0);
    push("rst_wmd", S_WMD, 32'h0);
    push("rst_srcA_pc", S_A1, 32'h40);
    tick(); tick();
    reset = 0;

    // Registers read zero after reset (r31 via A and B)
    loadIR(32'h03FF0000);
    tick();
    bus.ALUSrcA = 1;
    push("r31_a_zero", S_A1, 32'h0);
    push("r31_b_zero", S_WMD, 32'h0);
    tick();
    idle();

    // r1 = 0x100 via ALUOut write-back; B shows no same-cycle bypass
    loadIR(32'h00010000);
    bus.aluResult = 32'h100;
    tick();
    bus.RegWrite = 1;
    tick();
    bus.RegWrite = 0;
    push("r1_nobypass", S_WMD, 32'h0);
    tick();
    push("r1_written", S_WMD, 32'h100);
    tick();

    // Fetch with memReady low for two cycles
    bus.memData = 32'h8C220004; bus.IRWrite = 1; bus.memReady = 0;
    push("fetch_wait0_op", S_OP, 32'h0);
    push("fetch_wait0_pc", S_PC, 32'h40);
    tick();
    push("fetch_wait1_op", S_OP, 32'h0);
    tick();
    bus.memReady = 1; bus.PCWrite = 1; bus.PCSource = 0; bus.aluResult = 32'h44;
    push("fetch_wait2_op", S_OP, 32'h0);
    tick();
    idle();
    push("fetch_op", S_OP, 32'h23);
    push("fetch_funct", S_FUNCT, 32'h04);
    push("fetch_pc", S_PC, 32'h44);
    tick();

    // lw: address = r1 + 4, then MDR -> r2
    bus.ALUSrcA = 1; bus.ALUSrcB = 2; bus.ExtOp = 1;
    push("lw_srcA", S_A1, 32'h100);
    push("lw_srcB", S_A2, 32'h4);
    bus.aluResult = 32'h104;
    tick();
    idle();
    bus.IorD = 1;
    push("lw_maddr", S_MADDR, 32'h104);
    bus.memData = 32'hDEADBEEF; bus.memReady = 1;
    tick();
    idle();
    bus.RegWrite = 1; bus.MemToReg = 1; bus.RegDst = 0;
    tick();
    idle();
    push("lw_r2_old", S_WMD, 32'h0);
    tick();
    push("lw_r2_sw_data", S_WMD, 32'hDEADBEEF);
    tick();

    // Branches
    bus.PCWriteCondNe = 1; bus.zero = 1; bus.PCSource = 1; bus.aluResult = 32'h80;
    tick();
    push("bne_not_taken", S_PC, 32'h44);
    bus.zero = 0;
    tick();
    bus.PCWriteCondNe = 0;
    push("bne_taken", S_PC, 32'h80);
    bus.PCWriteCond = 1; bus.zero = 0; bus.PCSource = 0; bus.aluResult = 32'h90;
    tick();
    push("beq_not_taken", S_PC, 32'h80);
    bus.zero = 1;
    tick();
    idle();
    push("beq_taken", S_PC, 32'h90);

    // jal / jr
    bus.PCWrite = 1; bus.PCSource = 0; bus.aluResult = 32'h44;
    tick();
    idle();
    loadIR(32'h0C000010);
    push("jal_op", S_OP, 32'h03);
    bus.RegDst = 2; bus.MemToReg = 2; bus.RegWrite = 1; bus.PCWrite = 1; bus.PCSource = 2;
    tick();
    idle();
    push("jal_pc", S_PC, 32'h40);
    loadIR(32'h03E00008);
    tick();
    bus.ALUSrcA = 1;
    push("jal_r31_link", S_A1, 32'h44);
    push("jr_funct", S_FUNCT, 32'h08);
    bus.PCWrite = 1; bus.PCSource = 3;
    tick();
    idle();
    push("jr_pc", S_PC, 32'h44);

    // Stall freezes everything
    bus.aluResult = 32'h55;
    tick();
    bus.stall = 1; bus.RegWrite = 1; bus.RegDst = 2; bus.MemToReg = 0;
    bus.PCWrite = 1; bus.PCSource = 0; bus.aluResult = 32'h1234;
    bus.IRWrite = 1; bus.memReady = 1; bus.memData = 32'hFC00FFFF;
    repeat (3) tick();
    bus.IRWrite = 0; bus.PCWrite = 0; bus.RegWrite = 0; bus.memReady = 0;
    bus.IorD = 1; bus.ALUSrcA = 1;
    push("stall_pc", S_PC, 32'h44);
    push("stall_op", S_OP, 32'h0);
    push("stall_funct", S_FUNCT, 32'h08);
    push("stall_aluout", S_MADDR, 32'h55);
    push("stall_a", S_A1, 32'h44);
    tick();
    idle();
    tick();
    bus.ALUSrcA = 1;
    push("stall_r31_kept", S_A1, 32'h44);
    tick();
    idle();

    // r0 write discarded
    loadIR(32'h00000000);
    bus.aluResult = 32'h777;
    tick();
    bus.RegWrite = 1; bus.RegDst = 0; bus.MemToReg = 0;
    tick();
    idle();
    tick();
    bus.ALUSrcA = 1;
    push("r0_a", S_A1, 32'h0);
    push("r0_b", S_WMD, 32'h0);
    tick();
    idle();

    // Immediate extension (imm = 0xFFFF, rt = r1)
    loadIR(32'h2001FFFF);
    bus.ALUSrcB = 2; bus.ExtOp = 0;
    push("imm_zext", S_A2, 32'h0000FFFF);
    tick();
    bus.ExtOp = 1;
    push("imm_sext", S_A2, 32'hFFFFFFFF);
    tick();
    bus.ALUSrcB = 3;
    push("imm_sext_sh2", S_A2, 32'hFFFFFFFC);
    tick();
    bus.ALUSrcB = 1;
    push("srcB_four", S_A2, 32'h4);
    tick();
    bus.ALUSrcB = 0;
    push("srcB_b_r1", S_A2, 32'h100);
    tick();
    idle();

    // Asynchronous reset in the middle of a fetch
    bus.memData = 32'h8C220004; bus.IRWrite = 1; bus.memReady = 0;
    tick();
    #2 reset = 1;
    push("arst_pc", S_PC, 32'h40);
    push("arst_maddr", S_MADDR, 32'h40);
    push("arst_op", S_OP, 32'h0);
    push("arst_funct", S_FUNCT, 32'h0);
    push("arst_wmd", S_WMD, 32'h0);
    tick();
    reset = 0;
    idle();
    loadIR(32'h00220000);
    tick();
    bus.ALUSrcA = 1;
    push("arst_r1_clear", S_A1, 32'h0);
    push("arst_r2_clear", S_WMD, 32'h0);
    tick();
    idle();

    // Let the monitor drain, bounded
    repeat (3) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
      nBad += sbq.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
